// File: rtl/action_domain_reset_responder_if.sv
// ----------------------------------------------------------------------------
// action_domain_reset_responder_if
// Handshake bundle between one reset domain's responder and the reset handler
// and domain logic around it.
//   domain_rdy       : responder -> handler, domain has left reset and is idle
//   local_rst        : responder -> domain logic, async assert / sync deassert
//   local_idle       : domain logic -> responder, logic initialised and idle
//   watchdog_timeout : responder -> handler, ready was forced (sticky)
// Modports: slave = responder side, master = surrounding handler/domain side.
// ----------------------------------------------------------------------------
interface action_domain_reset_responder_if;
    logic domain_rdy;
    logic local_rst;
    logic local_idle;
    logic watchdog_timeout;

    modport slave  (output domain_rdy, output local_rst, output watchdog_timeout,
                    input  local_idle);
    modport master (input  domain_rdy, input  local_rst, input  watchdog_timeout,
                    output local_idle);
endinterface

// File: rtl/action_domain_reset_responder.sv
// ----------------------------------------------------------------------------
// action_domain_reset_responder
// Domain-side end of the reset sequencing chain, one instance per domain.
// Synchronises release of the incoming domain reset, holds the local reset for
// a settle period, then waits for the domain logic to report idle before
// returning ready to the upstream handler.
//
// Ports
//   i_clk        : domain clock
//   i_domain_rst : domain reset, asynchronous, active high
//   io_bus       : slave modport of action_domain_reset_responder_if
//                  (domain_rdy, local_rst, watchdog_timeout out; local_idle in)
//
// Build option
//   ACTION_DOMAIN_WATCHDOG_EN : when defined, WAIT_IDLE is bounded by a
//   watchdog that forces ready after WatchdogCycles+1 clocks and flags
//   watchdog_timeout. When undefined, WAIT_IDLE waits forever and
//   watchdog_timeout is tied low.
// ----------------------------------------------------------------------------
module action_domain_reset_responder #(
    parameter int SyncStages          = 2,
    parameter int SettleCycles        = 8,
    parameter int SettleCounterSize   = 4,
    parameter int WatchdogCycles      = 255,
    parameter int WatchdogCounterSize = 8
) (
    input  logic                            i_clk,
    input  logic                            i_domain_rst,
    action_domain_reset_responder_if.slave  io_bus
);

    // Elaboration-time parameter sanity checks.
    if (SyncStages < 2) begin : g_bad_sync
        $error("SyncStages must be >= 2");
    end
    if (SettleCycles < 0 || SettleCycles > (2 ** SettleCounterSize) - 1) begin : g_bad_settle
        $error("SettleCounterSize too small for SettleCycles");
    end
    if (WatchdogCycles < 0 || WatchdogCycles > (2 ** WatchdogCounterSize) - 1) begin : g_bad_wd
        $error("WatchdogCounterSize too small for WatchdogCycles");
    end

    typedef enum logic [1:0] {
        RST_HOLD  = 2'd0,
        SETTLE    = 2'd1,
        WAIT_IDLE = 2'd2,
        READY     = 2'd3
    } state_t;

    logic [SyncStages-1:0]        r_sync;
    logic                         w_rst_sync;
    state_t                       r_state;
    logic [SettleCounterSize-1:0] r_settle_cnt;
    logic                         r_local_rst;
    logic                         r_domain_rdy;
    logic                         r_wd_timeout;

    // Reset release synchroniser: sets to all ones asynchronously, drains
    // zeros in from the bottom once the domain reset is low.
    always_ff @(posedge i_clk or posedge i_domain_rst) begin
        if (i_domain_rst) r_sync <= '1;
        else              r_sync <= {r_sync[SyncStages-2:0], 1'b0};
    end
    assign w_rst_sync = r_sync[SyncStages-1];

`ifdef ACTION_DOMAIN_WATCHDOG_EN
    logic [WatchdogCounterSize-1:0] r_wd_cnt;
`endif

    always_ff @(posedge i_clk or posedge i_domain_rst) begin
        if (i_domain_rst) begin
            r_state      <= RST_HOLD;
            r_settle_cnt <= '0;
            r_local_rst  <= 1'b1;
            r_domain_rdy <= 1'b0;
            r_wd_timeout <= 1'b0;
`ifdef ACTION_DOMAIN_WATCHDOG_EN
            r_wd_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                RST_HOLD: begin
                    if (!w_rst_sync) begin
                        r_state      <= SETTLE;
                        r_settle_cnt <= SettleCounterSize'(SettleCycles);
                    end
                end
                SETTLE: begin
                    if (r_settle_cnt != '0) begin
                        r_settle_cnt <= r_settle_cnt - SettleCounterSize'(1);
                    end else begin
                        r_state     <= WAIT_IDLE;
                        r_local_rst <= 1'b0;
`ifdef ACTION_DOMAIN_WATCHDOG_EN
                        r_wd_cnt    <= WatchdogCounterSize'(WatchdogCycles);
`endif
                    end
                end
                WAIT_IDLE: begin
                    // Real idle wins over an expiring watchdog on the same edge.
                    if (io_bus.local_idle) begin
                        r_state      <= READY;
                        r_domain_rdy <= 1'b1;
                    end
`ifdef ACTION_DOMAIN_WATCHDOG_EN
                    else if (r_wd_cnt != '0) begin
                        r_wd_cnt <= r_wd_cnt - WatchdogCounterSize'(1);
                    end else begin
                        r_state      <= READY;
                        r_domain_rdy <= 1'b1;
                        r_wd_timeout <= 1'b1;
                    end
`endif
                end
                READY: begin
                    // Sticky until the next domain reset.
                end
                default: r_state <= RST_HOLD;
            endcase
        end
    end

    assign io_bus.local_rst        = r_local_rst;
    assign io_bus.domain_rdy       = r_domain_rdy;
    assign io_bus.watchdog_timeout = r_wd_timeout;

endmodule

// File: tb/tb_action_domain_reset_responder.sv
// Scoreboard bench: two responders (default timing, and 3-stage sync with no
// settle) share one reset and idle input. A per-edge reference model derived
// from "edges since release" arithmetic pushes expectations; a negedge
// monitor pops and compares.
module tb_action_domain_reset_responder;
    localparam int WD_CYC = 15;
    localparam int NI     = 2;

    logic clk;
    logic domain_rst;
    logic idle;

    action_domain_reset_responder_if if0 ();
    action_domain_reset_responder_if if1 ();
    assign if0.local_idle = idle;
    assign if1.local_idle = idle;

    action_domain_reset_responder #(
        .SyncStages(2), .SettleCycles(8), .SettleCounterSize(4),
        .WatchdogCycles(WD_CYC), .WatchdogCounterSize(4)
    ) dut0 (.i_clk(clk), .i_domain_rst(domain_rst), .io_bus(if0.slave));

    action_domain_reset_responder #(
        .SyncStages(3), .SettleCycles(0), .SettleCounterSize(4),
        .WatchdogCycles(WD_CYC), .WatchdogCounterSize(4)
    ) dut1 (.i_clk(clk), .i_domain_rst(domain_rst), .io_bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ACTION_DOMAIN_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    // Edge after which localRst drops: SyncStages + SettleCycles + 2.
    int lat [NI] = '{2 + 8 + 2, 3 + 0 + 2};
    int n   [NI];
    bit rdy [NI];
    bit to  [NI];

    typedef struct {
        logic [NI-1:0] lrst;
        logic [NI-1:0] rdy;
        logic [NI-1:0] to;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int passes = 0;

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            n[k] = 0; rdy[k] = 1'b0; to[k] = 1'b0;
        end
    endtask

    // One rising edge with the inputs currently applied.
    task automatic model_edge();
        if (domain_rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < NI; k++) begin
                n[k]++;
                if (!rdy[k] && n[k] > lat[k]) begin
                    if (idle) rdy[k] = 1'b1;
                    else if (WD_ON && n[k] == lat[k] + WD_CYC + 1) begin
                        rdy[k] = 1'b1; to[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            e.lrst[k] = domain_rst || (n[k] < lat[k]);
            e.rdy[k]  = rdy[k];
            e.to[k]   = to[k];
        end
        q.push_back(e);
    endtask

    // Edge, then change inputs mid-cycle; optional sub-cycle reset pulse.
    task automatic step(input logic r, input logic id, input logic pulse);
        @(posedge clk);
        model_edge();
        #2;
        domain_rst = r;
        idle       = id;
        if (r) model_reset();
        if (pulse) begin
            domain_rst = 1'b1;
            model_reset();
            #1;
            domain_rst = r;
        end
        push_exp();
    endtask

    task automatic chk(input string name, input logic act, input logic expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("dut0.localRst",        if0.local_rst,        e.lrst[0]);
            chk("dut0.domainRdy",       if0.domain_rdy,       e.rdy[0]);
            chk("dut0.watchdogTimeout", if0.watchdog_timeout, e.to[0]);
            chk("dut1.localRst",        if1.local_rst,        e.lrst[1]);
            chk("dut1.domainRdy",       if1.domain_rdy,       e.rdy[1]);
            chk("dut1.watchdogTimeout", if1.watchdog_timeout, e.to[1]);
        end
    end

    initial begin
        domain_rst = 1'b1;
        idle       = 1'b0;
        model_reset();

        // Reset held, then release with idle high.
        repeat (5) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);

        // Idle low until 20 clocks after dut0 localRst falls, one-clock pulse.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 45; i++) step(1'b0, (i == 31), 1'b0);

        // Async reassertion after edge 7 (mid-SETTLE), then full restart.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);

        // Async reassertion in READY, then a sub-cycle pulse in READY.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);

        // Idle never arrives: watchdog fires, or nothing happens for 1000 clocks.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) step(1'b0, 1'b0, 1'b0);

        // Random resets, pulses and idle.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 49) == 0));

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", (q.size() == 0), 1'b1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
